branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Control-step sequencer that drives the conditional-branch datapath and consumes the condition flip-flop result. It fetches a branch instruction and places the tested register on the bus while strobing `con_in`.
- After a fixed settling latency it samples the registered condition `con` and asserts `pc_in` with the branch target only when `con` = 1.
- It sits in the control unit between the fetch/decode logic and the datapath. It replaces hand-sequenced testbench control for branch instructions.

Parameters:
- BR_OPCODE, 5'b10010, value of `ir[31:27]` identifying a conditional branch.
- CON_LAT, 4, clock cycles `con_in` is held before `con` is sampled (range 1..15). This covers the condition flip-flop's internal register chain.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces IDLE and all outputs low
- start  input  1  request to execute one instruction from the current PC
- mem_ready  input  1  memory read data valid this cycle
- ir  input  32  instruction register contents
- con  input  1  registered condition result from the condition flip-flop
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the instruction retires
- illegal  output  1  one-cycle pulse, fetched opcode is not BR_OPCODE
- taken  output  1  qualifies `done`: 1 = branch taken, 0 = not taken
- pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdata_in, mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out  output  1 each  datapath strobes
- alu_add  output  1  ALU operation select = ADD

Behaviour:
- All outputs are Moore-decoded from state, except `pc_in` in T6.
- Reset value of every output is 0. An asynchronous reset mid-operation aborts immediately and leaves no strobe asserted; the next `start` begins a fresh fetch.
- IDLE: `start`=1 -> T0, else stay.
- T0: `pc_out`, `mar_in`, `inc_pc`, `z_in`. Go to T1 next cycle.
- T1: `zlow_out`, `pc_in`, `read`, `mdata_in`, `mdr_in` held every cycle while `mem_ready`=0.
  - `pc_in` is asserted only on the first T1 cycle, so the PC increments exactly once.
  - `mem_ready`=1 -> T2.
- T2: `mdr_out`, `ir_in`. Go to DEC.
- DEC: no strobes; examines `ir` (already loaded).
  - `ir[31:27]` != BR_OPCODE -> pulse `illegal`, go to IDLE, no `done`.
  - Otherwise load the latency counter with CON_LAT-1 and go to T3.
- T3: `gra`, `r_out`, `con_in`, held while the counter > 0. The counter decrements each cycle; counter = 0 -> T4.
  - `con_in` is therefore high for exactly CON_LAT consecutive cycles.
- T4: `pc_out`, `y_in`. Captures `con` into an internal `take` register; `take` is frozen from here to retirement.
- T5: `c_out`, `alu_add`, `z_in`.
- T6: `zlow_out`; `pc_in` = `take`.
  - Next state is IDLE with `done`=1 for one cycle and `taken` = `take` in that same cycle.
- `start` is ignored while `busy`=1.
- `start` held high in IDLE after `done` starts the next instruction on the following edge. There is no idle gap requirement.
- `con` changes outside T4 have no effect on the outcome.
- `mem_ready` asserted in T0 or any state other than T1 is ignored.
- Strobes in different T-states never overlap. In particular, `pc_in` is never high outside T1 (first cycle) and T6.

Test Plan:
- Reset mid-op: `reset` pulse asynchronously during T3 -> all outputs 0 immediately; `busy`=0 before the next clk edge; the following `start` produces T0 strobes.
- Taken branch: `start`; `mem_ready`=1 in first T1; `ir` = {5'b10010, 27'h0}; `con`=1 by T4 -> `con_in` high 4 cycles; `pc_in` in T6; `done`=1, `taken`=1.
  - Total 11 cycles from `start` edge to `done` (T0, T1, T2, DEC, 4×T3, T4, T5, T6).
- Not-taken branch: same as above with `con`=0 in T4; `con` toggles to 1 in T5 -> `pc_in` stays 0 in T6; `done`=1, `taken`=0.
- Memory wait: `mem_ready` low 3 cycles in T1 -> `read`/`mdr_in` held 4 cycles; `pc_in` high only on the first of them; sequence then continues normally.
- Illegal opcode: `ir[31:27]` = 5'b00011 -> `illegal` pulse in the cycle after DEC; no `con_in`, no `done`; `busy` drops.
- Latency parameter: CON_LAT=1 -> `con_in` high exactly 1 cycle. Back-to-back `start` held high -> second T0 follows `done` with no gap.

Source files
------------

// File: rtl/branch_sequencer_if.sv
// Control-unit <-> datapath bundle for the conditional-branch sequencer.
// The slave side is the sequencer; the master side is whoever feeds it instructions.
interface branch_sequencer_if;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic        con;

  logic        busy;
  logic        done;
  logic        illegal;
  logic        taken;

  logic        pc_out;
  logic        mar_in;
  logic        inc_pc;
  logic        z_in;
  logic        zlow_out;
  logic        pc_in;
  logic        read;
  logic        mdata_in;
  logic        mdr_in;
  logic        mdr_out;
  logic        ir_in;
  logic        gra;
  logic        r_out;
  logic        con_in;
  logic        y_in;
  logic        c_out;
  logic        alu_add;

  modport master (
    output start, mem_ready, ir, con,
    input  busy, done, illegal, taken,
    input  pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdata_in,
    input  mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add
  );

  modport slave (
    input  start, mem_ready, ir, con,
    output busy, done, illegal, taken,
    output pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdata_in,
    output mdr_in, mdr_out, ir_in, gra, r_out, con_in, y_in, c_out, alu_add
  );
endinterface

// File: rtl/branch_sequencer.sv
// Control-step sequencer for conditional branches: fetch, decode, condition
// evaluation with a fixed settling latency, then optional PC load of the target.
module branch_sequencer #(
  parameter logic [4:0]  BR_OPCODE = 5'b10010,
  parameter int unsigned CON_LAT   = 4
) (
  input  logic           clk,
  input  logic           reset,
  branch_sequencer_if.slave bus
);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, DEC, T3, T4, T5, T6} state_t;

  localparam logic [3:0] CNT_INIT = 4'(CON_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       take;
  logic       t1_seen;
  logic       done_q;
  logic       illegal_q;
  logic       taken_q;
  logic       opcode_ok;
  logic       unused_ir;

  assign opcode_ok = (bus.ir[31:27] == BR_OPCODE);
  assign unused_ir = ^bus.ir[26:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // t1_seen marks T1 cycles after the first, so the PC increments only once
  // however long memory stalls; retire pulses are registered into IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      take      <= 1'b0;
      t1_seen   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      taken_q   <= 1'b0;
    end else begin
      t1_seen   <= (state == T1);
      done_q    <= (state == T6);
      taken_q   <= (state == T6) && take;
      illegal_q <= (state == DEC) && !opcode_ok;
      if (state == DEC)
        cnt <= CNT_INIT;
      else if ((state == T3) && (cnt != 4'd0))
        cnt <= cnt - 4'd1;
      if (state == T4)
        take <= bus.con;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = T0;
      T0:      state_nxt = T1;
      T1:      if (bus.mem_ready) state_nxt = T2;
      T2:      state_nxt = DEC;
      DEC:     state_nxt = opcode_ok ? T3 : IDLE;
      T3:      if (cnt == 4'd0) state_nxt = T4;
      T4:      state_nxt = T5;
      T5:      state_nxt = T6;
      T6:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state != IDLE);
    bus.done     = done_q;
    bus.illegal  = illegal_q;
    bus.taken    = taken_q;
    bus.pc_out   = 1'b0;
    bus.mar_in   = 1'b0;
    bus.inc_pc   = 1'b0;
    bus.z_in     = 1'b0;
    bus.zlow_out = 1'b0;
    bus.pc_in    = 1'b0;
    bus.read     = 1'b0;
    bus.mdata_in = 1'b0;
    bus.mdr_in   = 1'b0;
    bus.mdr_out  = 1'b0;
    bus.ir_in    = 1'b0;
    bus.gra      = 1'b0;
    bus.r_out    = 1'b0;
    bus.con_in   = 1'b0;
    bus.y_in     = 1'b0;
    bus.c_out    = 1'b0;
    bus.alu_add  = 1'b0;
    case (state)
      T0: begin
        bus.pc_out = 1'b1;
        bus.mar_in = 1'b1;
        bus.inc_pc = 1'b1;
        bus.z_in   = 1'b1;
      end
      T1: begin
        bus.zlow_out = 1'b1;
        bus.pc_in    = !t1_seen;
        bus.read     = 1'b1;
        bus.mdata_in = 1'b1;
        bus.mdr_in   = 1'b1;
      end
      T2: begin
        bus.mdr_out = 1'b1;
        bus.ir_in   = 1'b1;
      end
      T3: begin
        bus.gra    = 1'b1;
        bus.r_out  = 1'b1;
        bus.con_in = 1'b1;
      end
      T4: begin
        bus.pc_out = 1'b1;
        bus.y_in   = 1'b1;
      end
      T5: begin
        bus.c_out   = 1'b1;
        bus.alu_add = 1'b1;
        bus.z_in    = 1'b1;
      end
      T6: begin
        bus.zlow_out = 1'b1;
        bus.pc_in    = take;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: two instances (CON_LAT=4 and CON_LAT=1),
// expected retirements queued at issue and checked by a monitor at retirement.
module tb_branch_sequencer;

  typedef struct {
    bit ill;
    bit dn;
    bit tk;
    int busy_n;
    int con_n;
    int pc_n;
    int read_n;
  } rec_t;

  logic clk;
  logic reset;

  branch_sequencer_if bus0();
  branch_sequencer_if bus1();

  branch_sequencer #(.CON_LAT(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  branch_sequencer #(.CON_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  logic [1:0]  start_v;
  logic [1:0]  mr_v;
  logic [1:0]  con_v;
  logic [31:0] ir_v [2];

  assign bus0.start     = start_v[0];
  assign bus0.mem_ready = mr_v[0];
  assign bus0.con       = con_v[0];
  assign bus0.ir        = ir_v[0];
  assign bus1.start     = start_v[1];
  assign bus1.mem_ready = mr_v[1];
  assign bus1.con       = con_v[1];
  assign bus1.ir        = ir_v[1];

  logic [1:0] busy_v, done_v, ill_v, taken_v, con_in_v, pc_in_v, read_v;
  logic [4:0] t0_v [2];
  logic [20:0] all0;

  assign busy_v   = {bus1.busy,    bus0.busy};
  assign done_v   = {bus1.done,    bus0.done};
  assign ill_v    = {bus1.illegal, bus0.illegal};
  assign taken_v  = {bus1.taken,   bus0.taken};
  assign con_in_v = {bus1.con_in,  bus0.con_in};
  assign pc_in_v  = {bus1.pc_in,   bus0.pc_in};
  assign read_v   = {bus1.read,    bus0.read};
  assign t0_v[0]  = {bus0.busy, bus0.pc_out, bus0.mar_in, bus0.inc_pc, bus0.z_in};
  assign t0_v[1]  = {bus1.busy, bus1.pc_out, bus1.mar_in, bus1.inc_pc, bus1.z_in};
  assign all0 = {bus0.busy, bus0.done, bus0.illegal, bus0.taken, bus0.pc_out,
                 bus0.mar_in, bus0.inc_pc, bus0.z_in, bus0.zlow_out, bus0.pc_in,
                 bus0.read, bus0.mdata_in, bus0.mdr_in, bus0.mdr_out, bus0.ir_in,
                 bus0.gra, bus0.r_out, bus0.con_in, bus0.y_in, bus0.c_out, bus0.alu_add};

  int checks = 0;
  int errors = 0;
  rec_t expq0[$];
  rec_t expq1[$];
  rec_t acc [2];

  localparam logic [31:0] IR_BR  = {5'b10010, 27'h0};
  localparam logic [31:0] IR_ILL = {5'b00011, 27'h0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic rec_t mkRec(bit ill, bit dn, bit tk, int busy_n, int con_n,
                                 int pc_n, int read_n);
    rec_t r;
    r.ill = ill; r.dn = dn; r.tk = tk; r.busy_n = busy_n;
    r.con_n = con_n; r.pc_n = pc_n; r.read_n = read_n;
    return r;
  endfunction

  task automatic checkOutput(input int idx, input rec_t got);
    rec_t e;
    string p;
    p = $sformatf("dut%0d", idx);
    if ((idx == 0 && expq0.size() == 0) || (idx == 1 && expq1.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_unexpected_retire: got retirement expected none", p);
      return;
    end
    e = (idx == 0) ? expq0.pop_front() : expq1.pop_front();
    chk({p, "_illegal"},     int'(got.ill), int'(e.ill));
    chk({p, "_done"},        int'(got.dn),  int'(e.dn));
    chk({p, "_taken"},       int'(got.tk),  int'(e.tk));
    chk({p, "_busy_cycles"}, got.busy_n,    e.busy_n);
    chk({p, "_con_in_cyc"},  got.con_n,     e.con_n);
    chk({p, "_pc_in_cyc"},   got.pc_n,      e.pc_n);
    chk({p, "_read_cyc"},    got.read_n,    e.read_n);
  endtask

  // Monitor: accumulates strobe activity per instruction and scores it at retirement.
  initial begin
    acc[0] = mkRec(0, 0, 0, 0, 0, 0, 0);
    acc[1] = mkRec(0, 0, 0, 0, 0, 0, 0);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          acc[i] = mkRec(0, 0, 0, 0, 0, 0, 0);
        end else begin
          acc[i].busy_n += int'(busy_v[i]);
          acc[i].con_n  += int'(con_in_v[i]);
          acc[i].pc_n   += int'(pc_in_v[i]);
          acc[i].read_n += int'(read_v[i]);
          if (done_v[i] || ill_v[i]) begin
            acc[i].ill = ill_v[i];
            acc[i].dn  = done_v[i];
            acc[i].tk  = taken_v[i];
            checkOutput(i, acc[i]);
            acc[i] = mkRec(0, 0, 0, 0, 0, 0, 0);
          end
        end
      end
    end
  end

  // Drives one instruction, starting just before the edge that samples start and
  // returning at the negedge of the retirement cycle.
  task automatic applyStimulus(input int idx, input bit keep, input logic [31:0] irv,
                               input bit con4, input bit con5, input int nwait,
                               input int lat, input rec_t exp);
    if (idx == 0) expq0.push_back(exp);
    else          expq1.push_back(exp);
    start_v[idx] = 1'b1;
    mr_v[idx]    = 1'b0;
    ir_v[idx]    = irv;
    con_v[idx]   = !con4;
    @(negedge clk);
    chk($sformatf("dut%0d_t0_strobes", idx), int'(t0_v[idx]), 31);
    if (!keep) start_v[idx] = 1'b0;
    mr_v[idx] = (nwait > 0);
    for (int k = 0; k <= nwait; k++) begin
      @(negedge clk);
      mr_v[idx] = (k == nwait);
    end
    @(negedge clk);
    mr_v[idx] = 1'b0;
    @(negedge clk);
    if (irv[31:27] != 5'b10010) begin
      @(negedge clk);
      return;
    end
    for (int j = 0; j < lat; j++) @(negedge clk);
    @(negedge clk);
    con_v[idx] = con4;
    @(negedge clk);
    con_v[idx] = con5;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    start_v = '0;
    mr_v    = '0;
    con_v   = '0;
    ir_v[0] = '0;
    ir_v[1] = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'(all0), 0);
    reset = 1'b0;
    @(negedge clk);

    // Abort in T3 with an asynchronous reset pulse.
    start_v[0] = 1'b1;
    ir_v[0]    = IR_BR;
    @(negedge clk);
    start_v[0] = 1'b0;
    mr_v[0]    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mr_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_t3_con_in", int'(con_in_v[0]), 1);
    #2 reset = 1'b1;
    #1 chk("abort_outputs_zero", int'(all0), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    chk("abort_busy_after", int'(busy_v[0]), 0);
    @(negedge clk);

    $display("[TB] taken branch");
    applyStimulus(0, 0, IR_BR, 1, 0, 0, 4, mkRec(0, 1, 1, 11, 4, 2, 1));
    @(negedge clk);
    $display("[TB] not-taken branch, con rises in T5");
    applyStimulus(0, 0, IR_BR, 0, 1, 0, 4, mkRec(0, 1, 0, 11, 4, 1, 1));
    @(negedge clk);
    $display("[TB] memory wait of 3 cycles");
    applyStimulus(0, 0, IR_BR, 1, 1, 3, 4, mkRec(0, 1, 1, 14, 4, 2, 4));
    @(negedge clk);
    $display("[TB] illegal opcode");
    applyStimulus(0, 0, IR_ILL, 1, 1, 0, 4, mkRec(1, 0, 0, 4, 0, 1, 1));
    @(negedge clk);
    chk("illegal_busy_dropped", int'(busy_v[0]), 0);

    $display("[TB] CON_LAT=1, back-to-back with start held");
    applyStimulus(1, 1, IR_BR, 1, 0, 0, 1, mkRec(0, 1, 1, 8, 1, 2, 1));
    applyStimulus(1, 0, IR_BR, 0, 1, 0, 1, mkRec(0, 1, 0, 8, 1, 1, 1));

    repeat (5) @(negedge clk);
    chk("pending_expectations", expq0.size() + expq1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
